// File: rtl/not_gate_reg_pkg.sv
// Shared constants for the conditional-inverter datapath primitive.
package not_gate_reg_pkg;

  localparam int MAX_WIDTH       = 64;
  localparam int MAX_PIPE_STAGES = 4;

endpackage

// File: rtl/not_gate_reg_if.sv
// Data/valid bundle for the conditional inverter: the producer drives a, b and
// in_valid; the inverter returns y and out_valid.
interface not_gate_reg_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic [WIDTH-1:0] y;
  logic             out_valid;

  modport master (
    output a,
    output b,
    output in_valid,
    input  y,
    input  out_valid
  );

  modport slave (
    input  a,
    input  b,
    input  in_valid,
    output y,
    output out_valid
  );

endinterface

// File: rtl/not_gate_reg_stage.sv
// One register stage of the inverter pipeline: WIDTH data bits plus a valid bit,
// cleared immediately by the asynchronous reset.
module not_gate_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  // Data loads every cycle regardless of valid; valid travels alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/not_gate_reg.sv
// Per-bit conditional inverter (y = a XOR b) followed by an optional chain of
// register stages that carry the valid flag along with the result.
module not_gate_reg
  import not_gate_reg_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int PIPE_STAGES = 1
) (
  input  logic           clk,
  input  logic           rst,
  not_gate_reg_if.slave  bus
);

  // Out-of-range parameters stop elaboration rather than build a wrong datapath.
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $fatal(1, "not_gate_reg: WIDTH=%0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end
  if (PIPE_STAGES < 0 || PIPE_STAGES > MAX_PIPE_STAGES) begin : g_bad_stages
    $fatal(1, "not_gate_reg: PIPE_STAGES=%0d outside 0..%0d", PIPE_STAGES, MAX_PIPE_STAGES);
  end

  // Index 0 is the combinational XOR result; index k is the output of stage k.
  logic [WIDTH-1:0] stage_y [0:PIPE_STAGES];
  logic             stage_v [0:PIPE_STAGES];

  // Setting an enable bit flips the matching data bit; bits never interact.
  always_comb begin
    stage_y[0] = bus.a ^ bus.b;
    stage_v[0] = bus.in_valid;
  end

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
    not_gate_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .d       (stage_y[i]),
      .d_valid (stage_v[i]),
      .q       (stage_y[i+1]),
      .q_valid (stage_v[i+1])
    );
  end

  // The last element is the XOR itself when there are no stages.
  always_comb begin
    bus.y         = stage_y[PIPE_STAGES];
    bus.out_valid = stage_v[PIPE_STAGES];
  end

endmodule

// File: tb/tb_not_gate_reg.sv
// Self-checking bench for not_gate_reg: four instances (W1/P1, W8/P1, W8/P3,
// W4/P0) share clock and reset; a history-based model predicts every output.
module tb_not_gate_reg;

  logic clk;
  logic rst;

  int n_compared = 0;
  int n_mismatch = 0;

  not_gate_reg_if #(.WIDTH(1)) bus1 ();
  not_gate_reg_if #(.WIDTH(8)) bus8 ();
  not_gate_reg_if #(.WIDTH(8)) bus8p ();
  not_gate_reg_if #(.WIDTH(4)) bus4 ();

  not_gate_reg #(.WIDTH(1), .PIPE_STAGES(1)) dut_w1 (.clk(clk), .rst(rst), .bus(bus1));
  not_gate_reg #(.WIDTH(8), .PIPE_STAGES(1)) dut_w8 (.clk(clk), .rst(rst), .bus(bus8));
  not_gate_reg #(.WIDTH(8), .PIPE_STAGES(3)) dut_p3 (.clk(clk), .rst(rst), .bus(bus8p));
  not_gate_reg #(.WIDTH(4), .PIPE_STAGES(0)) dut_c0 (.clk(clk), .rst(rst), .bus(bus4));

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-extended views of each instance, indexed 0..3 in the order above.
  logic [63:0] cur_a [4];
  logic [63:0] cur_b [4];
  logic        cur_v [4];
  logic [63:0] cur_y [4];
  logic        cur_ov [4];

  assign cur_a[0] = 64'(bus1.a);   assign cur_b[0] = 64'(bus1.b);
  assign cur_a[1] = 64'(bus8.a);   assign cur_b[1] = 64'(bus8.b);
  assign cur_a[2] = 64'(bus8p.a);  assign cur_b[2] = 64'(bus8p.b);
  assign cur_a[3] = 64'(bus4.a);   assign cur_b[3] = 64'(bus4.b);
  assign cur_v[0] = bus1.in_valid;  assign cur_v[1] = bus8.in_valid;
  assign cur_v[2] = bus8p.in_valid; assign cur_v[3] = bus4.in_valid;
  assign cur_y[0] = 64'(bus1.y);   assign cur_y[1] = 64'(bus8.y);
  assign cur_y[2] = 64'(bus8p.y);  assign cur_y[3] = 64'(bus4.y);
  assign cur_ov[0] = bus1.out_valid;  assign cur_ov[1] = bus8.out_valid;
  assign cur_ov[2] = bus8p.out_valid; assign cur_ov[3] = bus4.out_valid;

  function automatic int pipes_of(input int d);
    case (d)
      0: return 1;
      1: return 1;
      2: return 3;
      default: return 0;
    endcase
  endfunction

  // Model state: what each instance saw at every rising edge, and the last
  // edge index at or before which a reset wiped the pipeline.
  int          cyc      = 0;
  int          last_rst = 0;
  logic [63:0] hist_y [4][1024];
  logic        hist_v [4][1024];

  // Record the XOR result and qualifier each instance is handed at this edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) last_rst = cyc;
    for (int d = 0; d < 4; d++) begin
      hist_y[d][cyc] = cur_a[d] ^ cur_b[d];
      hist_v[d][cyc] = cur_v[d];
    end
  end

  // A reset pulse between edges also discards everything captured so far.
  always @(posedge rst) last_rst = cyc;

  // Output of an N-stage instance is its input from N-1 edges earlier, unless a
  // reset has happened since that capture (then everything reads back as 0).
  task automatic model_out(input int d, output logic [63:0] ey, output logic ev);
    int n;
    int cap;
    n = pipes_of(d);
    ey = '0;
    ev = 1'b0;
    if (n == 0) begin
      ey = cur_a[d] ^ cur_b[d];
      ev = cur_v[d];
    end else if (!rst) begin
      cap = cyc - n + 1;
      if (cap >= 1 && cap > last_rst) begin
        ey = hist_y[d][cap];
        ev = hist_v[d][cap];
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Compare every instance against the model midway between rising edges.
  always @(negedge clk) begin
    logic [63:0] ey;
    logic        ev;
    for (int d = 0; d < 4; d++) begin
      model_out(d, ey, ev);
      checkOutput($sformatf("model_y[%0d]@%0d", d, cyc), cur_y[d], ey);
      checkOutput($sformatf("model_v[%0d]@%0d", d, cyc), 64'(cur_ov[d]), 64'(ev));
    end
  end

  task automatic applyStimulus(input int d, input logic [63:0] a, input logic [63:0] b, input logic v);
    case (d)
      0: begin bus1.a = a[0:0];   bus1.b = b[0:0];   bus1.in_valid = v;  end
      1: begin bus8.a = a[7:0];   bus8.b = b[7:0];   bus8.in_valid = v;  end
      2: begin bus8p.a = a[7:0];  bus8p.b = b[7:0];  bus8p.in_valid = v; end
      default: begin bus4.a = a[3:0]; bus4.b = b[3:0]; bus4.in_valid = v; end
    endcase
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  tt_a    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0]  tt_b    [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0]  tt_y    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [63:0] pipe_y  [3] = '{64'h0E, 64'h0D, 64'h0C};

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 4; d++) applyStimulus(d, 64'h0, 64'h0, 1'b0);

    // Reset held across edges, then released between edges.
    repeat (2) @(posedge clk);
    #3;
    checkOutput("rst_hold_y", cur_y[0], 64'h0);
    checkOutput("rst_hold_v", 64'(cur_ov[0]), 64'h0);
    rst = 1'b0;
    applyStimulus(0, 64'h1, 64'h0, 1'b1);
    step_cycle();
    checkOutput("release_first_y", cur_y[0], 64'h1);
    checkOutput("release_first_v", 64'(cur_ov[0]), 64'h1);

    // Single-bit truth table, one cycle of latency.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 64'(tt_a[i]), 64'(tt_b[i]), 1'b1);
      step_cycle();
      checkOutput($sformatf("truth_y[%0d]", i), cur_y[0], 64'(tt_y[i]));
      checkOutput($sformatf("truth_v[%0d]", i), 64'(cur_ov[0]), 64'h1);
    end

    // Reset asserted between edges clears outputs without a clock edge.
    applyStimulus(0, 64'h1, 64'h0, 1'b1);
    step_cycle();
    checkOutput("pre_async_y", cur_y[0], 64'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_y", cur_y[0], 64'h0);
    checkOutput("async_rst_v", 64'(cur_ov[0]), 64'h0);
    step_cycle();
    #2 rst = 1'b0;
    applyStimulus(0, 64'h0, 64'h0, 1'b0);

    // Plain NOT on 8 bits.
    applyStimulus(1, 64'hA5, 64'hFF, 1'b1);
    step_cycle();
    checkOutput("not_a5", cur_y[1], 64'h5A);
    applyStimulus(1, 64'h00, 64'hFF, 1'b1);
    step_cycle();
    checkOutput("not_00", cur_y[1], 64'hFF);
    checkOutput("not_00_v", 64'(cur_ov[1]), 64'h1);
    applyStimulus(1, 64'h0, 64'h0, 1'b0);

    // Three-stage stream 1,2,3 then a gap.
    for (int i = 0; i < 6; i++) begin
      if (i < 3) applyStimulus(2, 64'(i + 1), 64'h0F, 1'b1);
      else       applyStimulus(2, 64'h0, 64'h0F, 1'b0);
      step_cycle();
      if (i >= 2 && i <= 4) begin
        checkOutput($sformatf("pipe_y[%0d]", i - 2), cur_y[2], pipe_y[i - 2]);
        checkOutput($sformatf("pipe_v[%0d]", i - 2), 64'(cur_ov[2]), 64'h1);
      end else if (i == 5) begin
        checkOutput("pipe_gap_v", 64'(cur_ov[2]), 64'h0);
      end else begin
        checkOutput($sformatf("pipe_fill_v[%0d]", i), 64'(cur_ov[2]), 64'h0);
      end
    end

    // Reset while two results are in flight: they must never emerge.
    applyStimulus(2, 64'h07, 64'h00, 1'b1);
    step_cycle();
    applyStimulus(2, 64'h08, 64'h00, 1'b1);
    step_cycle();
    applyStimulus(2, 64'h00, 64'h00, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_v", 64'(cur_ov[2]), 64'h0);
    step_cycle();
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step_cycle();
      checkOutput($sformatf("mid_rst_drop_v[%0d]", i), 64'(cur_ov[2]), 64'h0);
    end

    // Combinational instance responds within the same cycle.
    applyStimulus(3, 64'hC, 64'hA, 1'b1);
    #1;
    checkOutput("comb_y", cur_y[3], 64'h6);
    checkOutput("comb_v", 64'(cur_ov[3]), 64'h1);
    applyStimulus(3, 64'hC, 64'hA, 1'b0);
    #1;
    checkOutput("comb_v_low", 64'(cur_ov[3]), 64'h0);

    // Mixed traffic on every instance, with gaps, checked by the model.
    for (int i = 0; i < 24; i++) begin
      for (int d = 0; d < 4; d++)
        applyStimulus(d, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      step_cycle();
    end
    for (int d = 0; d < 4; d++) applyStimulus(d, 64'h0, 64'h0, 1'b0);
    repeat (5) step_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
